prbs_burst_controller: RTL and testbench
========================================

Name: prbs_burst_controller

Overview:
- Sequences a Fibonacci LFSR PRBS generator in bursts of a programmed number of steps.
- The LFSR advances only on a slow tick strobe, normally the 1 Hz enable from the clock divider.
- Provides start/busy/done handshake, pause, abort and seed loading with zero-seed protection.
- Sits between board controls (switches/buttons) and the LED/output stage that displays the PRBS state.

Parameters:
- WIDTH, 4, LFSR register width (>=3).
- TAPS, 4'b1100, feedback mask; bit i set -> state[i] enters the XOR (default x^4+x^3+1, period 15).
- LEN_W, 8, width of burst length and step counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_en  in  1  single-cycle step strobe from divider
- start  in  1  begin burst (sampled in IDLE only)
- seed  in  WIDTH  initial LFSR state, latched on accepted start
- burst_len  in  LEN_W  steps to emit, latched on accepted start
- pause  in  1  level; freezes stepping while high
- abort  in  1  terminate burst, return to IDLE
- lfsr_out  out  WIDTH  emitted LFSR state (registered)
- bit_out  out  1  lfsr_out[WIDTH-1] of emitted state
- valid  out  1  one-cycle pulse per emitted step
- busy  out  1  high in LOAD/RUN/PAUSED/DONE
- done  out  1  one-cycle pulse at normal burst completion
- wrap  out  1  one-cycle pulse, with valid, when next state equals latched seed
- seed_fixed  out  1  one-cycle pulse when a zero seed was replaced

Behaviour:
- Reset, synchronous: state=IDLE; LFSR reg, step count, latched seed/len = 0; all outputs 0.
- LFSR step: fb = XOR(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Zero seed is illegal (lock-up): load 1 instead and pulse seed_fixed during the LOAD cycle.
- IDLE: busy=0. If start=1 -> LOAD; latch seed and burst_len. Inputs ignored otherwise.
- LOAD, one cycle: LFSR reg <= latched seed, count <= 0.
  - If burst_len==0 -> DONE.
  - Else -> RUN.
- RUN, tick_en=1 and pause=0 and abort=0: on that edge, lfsr_out <= current state, bit_out <= its MSB, valid=1, LFSR <= next, count <= count+1.
  - wrap=1 in the same cycle as valid if next==latched seed.
  - If count+1==burst_len -> DONE.
- RUN, pause=1 -> PAUSED. Pause beats a same-cycle tick: no step taken.
- PAUSED: ticks discarded, not queued. pause=0 -> RUN; the next tick is accepted.
- DONE, one cycle: done=1, then IDLE. lfsr_out holds last emitted value.
- abort=1 in LOAD/RUN/PAUSED/DONE -> IDLE on the next edge. No valid, no done. Abort beats tick and pause. lfsr_out holds.
- start while busy is ignored. start and abort in the same IDLE cycle: start accepted.
- Latency: start at edge n -> LOAD after n, RUN after n+1. Earliest valid is the cycle after the first tick sampled in RUN.
- Count arithmetic: unsigned LEN_W; burst_len=2^LEN_W-1 is the max. Bursts longer than 2^WIDTH-1 simply wrap the sequence and pulse wrap each period.
- reset has priority over every input in every state.

Decomposition:
- Shared package prbs_pkg holds:
  - state enum (IDLE, LOAD, RUN, PAUSED, DONE);
  - default WIDTH/TAPS constants;
  - a function lfsr_next(state, taps).
- One natural sub-module: prbs_lfsr_core. It holds the WIDTH-bit register with ports load, load_val, step and state_q. The controller FSM, counter and output registers stay in the top.

Test Plan:
- Reset mid-RUN: assert reset during a burst -> next cycle all outputs 0, busy=0, state IDLE.
- Basic sequence: seed=0001, len=5, tick every 4 clk -> valid pulses with lfsr_out 0001, 0010, 0100, 1001, 0011; done one cycle after the 5th step; bit_out 0,0,0,1,0.
- Wrap: seed=0001, len=16 -> 16 valid pulses; wrap only on the 15th (emitted 1000); 16th emits 0001; done follows.
- Zero seed and zero length:
  - seed=0000, len=3 -> seed_fixed pulse, outputs 0001, 0010, 0100.
  - seed=0101, len=0 -> done two cycles after start, no valid.
- Pause/abort/priority:
  - pause over 3 ticks -> no valid, sequence resumes from the paused state.
  - tick+pause in the same cycle -> no step.
  - abort+tick -> no valid, no done, IDLE next cycle.
  - start while busy -> ignored.

Source files
------------

// File: rtl/prbs_burst_controller_pkg.sv
// prbs_burst_controller_pkg: shared FSM states, default LFSR shape and the PRBS step function.
package prbs_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 4'b1100;
  localparam int DEF_LEN_W = 8;
  localparam int LFSR_MAX_W = 32;
  // Width-agnostic Fibonacci step; callers zero-extend and truncate to their own width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] s, input logic [LFSR_MAX_W-1:0] taps);
    return {s[LFSR_MAX_W-2:0], ^(s & taps)};
  endfunction
endpackage

// File: rtl/prbs_burst_controller_if.sv
// prbs_burst_controller_if: board-control inputs and PRBS display outputs of the burst controller.
interface prbs_burst_controller_if import prbs_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
);
  logic tick_en, start, pause, abort;
  logic [WIDTH-1:0] seed, lfsr_out;
  logic [LEN_W-1:0] burst_len;
  logic bit_out, valid, busy, done, wrap, seed_fixed;
  modport master(
    output tick_en, start, seed, burst_len, pause, abort,
    input lfsr_out, bit_out, valid, busy, done, wrap, seed_fixed
  );
  modport slave(
    input tick_en, start, seed, burst_len, pause, abort,
    output lfsr_out, bit_out, valid, busy, done, wrap, seed_fixed
  );
endinterface

// File: rtl/prbs_burst_controller_lfsr_core.sv
// prbs_lfsr_core: WIDTH-bit Fibonacci LFSR register with load and single-step controls.
module prbs_lfsr_core import prbs_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state_q
);
  always_ff @(posedge clk)
    if (reset) state_q <= '0;
    else if (load) state_q <= load_val;
    else if (step) state_q <= WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
endmodule

// File: rtl/prbs_burst_controller.sv
// prbs_burst_controller: runs the PRBS LFSR for a programmed number of tick-paced steps
// with start/busy/done handshake, pause, abort and zero-seed protection.
module prbs_burst_controller import prbs_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
  parameter int LEN_W = DEF_LEN_W
) (
  input logic clk,
  input logic reset,
  prbs_burst_controller_if.slave bus
);
  state_t r_state;
  logic [WIDTH-1:0] r_seed, r_lfsr_out, w_lfsr, w_next;
  logic [LEN_W-1:0] r_len, r_cnt, w_cnt_inc;
  logic r_valid, r_done, r_wrap, r_fix;
  logic w_load, w_step;
  assign w_load = (r_state == LOAD) && !bus.abort;
  assign w_step = (r_state == RUN) && bus.tick_en && !bus.pause && !bus.abort;
  assign w_next = WIDTH'(lfsr_next(LFSR_MAX_W'(w_lfsr), LFSR_MAX_W'(TAPS)));
  assign w_cnt_inc = r_cnt + 1'b1;
  prbs_lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk(clk), .reset(reset), .load(w_load), .load_val(r_seed), .step(w_step), .state_q(w_lfsr)
  );
  // Seed is latched already repaired so wrap detection compares against what was really loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_seed <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_lfsr_out <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_fix <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_fix <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_seed <= (bus.seed == '0) ? WIDTH'(1) : bus.seed;
          r_fix <= bus.seed == '0;
          r_len <= bus.burst_len;
          r_state <= LOAD;
        end
        LOAD: begin
          r_cnt <= '0;
          r_state <= bus.abort ? IDLE : (r_len == '0) ? DONE : RUN;
        end
        RUN: if (bus.abort) r_state <= IDLE;
        else if (bus.pause) r_state <= PAUSED;
        else if (bus.tick_en) begin
          r_lfsr_out <= w_lfsr;
          r_valid <= 1'b1;
          r_wrap <= w_next == r_seed;
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == r_len) r_state <= DONE;
        end
        PAUSED: r_state <= bus.abort ? IDLE : bus.pause ? PAUSED : RUN;
        DONE: begin
          r_done <= !bus.abort;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.lfsr_out = r_lfsr_out;
  assign bus.bit_out = r_lfsr_out[WIDTH-1];
  assign bus.valid = r_valid;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  assign bus.wrap = r_wrap;
  assign bus.seed_fixed = r_fix;
endmodule

// File: tb/tb_prbs_burst_controller.sv
// tb_prbs_burst_controller: directed bursts with a scoreboard of expected valid/done/seed_fixed events.
module tb_prbs_burst_controller;
  localparam logic [1:0] K_VAL = 2'd0, K_DONE = 2'd1, K_FIX = 2'd2;
  typedef struct packed {logic [1:0] k; logic [3:0] v; logic b; logic w;} ev_t;
  logic clk = 1'b0, reset = 1'b1;
  int n_chk = 0, n_fail = 0;
  ev_t exp_q[$];
  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  prbs_burst_controller_if #(.WIDTH(4), .LEN_W(8)) bus();
  prbs_burst_controller #(.WIDTH(4), .TAPS(4'b1100), .LEN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic mon(input logic [1:0] k);
    ev_t g, e;
    g = '{k: k, v: (k == K_VAL) ? bus.lfsr_out : 4'h0, b: (k == K_VAL) ? bus.bit_out : 1'b0, w: (k == K_VAL) ? bus.wrap : 1'b0};
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event got=%0h", g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL event got=%0h exp=%0h", g, e);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bus.seed_fixed) mon(K_FIX);
    if (bus.valid) mon(K_VAL);
    if (bus.done) mon(K_DONE);
  end
  task automatic push_run(input int i0, input int n, input logic [3:0] seed);
    for (int j = 0; j < n; j++) begin
      logic [3:0] v;
      v = seq[(i0 + j) % 15];
      exp_q.push_back('{k: K_VAL, v: v, b: v[3], w: seq[(i0 + j + 1) % 15] == seed});
    end
  endtask
  task automatic push_k(input logic [1:0] k);
    exp_q.push_back('{k: k, v: 4'h0, b: 1'b0, w: 1'b0});
  endtask
  task automatic start_burst(input logic [3:0] s, input logic [7:0] l);
    @(negedge clk);
    bus.seed = s;
    bus.burst_len = l;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) @(negedge clk);
      bus.tick_en = 1'b1;
      @(negedge clk);
      bus.tick_en = 1'b0;
    end
  endtask
  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask
  function automatic logic [10:0] outs();
    return {bus.lfsr_out, bus.bit_out, bus.valid, bus.busy, bus.done, bus.wrap, bus.seed_fixed, 1'b0};
  endfunction
  initial begin
    {bus.tick_en, bus.start, bus.pause, bus.abort} = '0;
    bus.seed = '0;
    bus.burst_len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    // basic burst
    push_run(0, 5, 4'h1);
    push_k(K_DONE);
    start_burst(4'h1, 8'd5);
    check("busy_load", bus.busy, 1);
    ticks(5);
    drain("basic_drain");
    check("basic_idle", bus.busy, 0);
    check("basic_hold", bus.lfsr_out, 4'h3);
    // full period plus one: wrap on the 15th step only
    push_run(0, 16, 4'h1);
    push_k(K_DONE);
    start_burst(4'h1, 8'd16);
    ticks(16);
    drain("wrap_drain");
    // zero seed repaired to 1
    push_k(K_FIX);
    push_run(0, 3, 4'h1);
    push_k(K_DONE);
    start_burst(4'h0, 8'd3);
    ticks(3);
    drain("zero_seed_drain");
    // zero length: done two cycles after start, no valid
    push_k(K_DONE);
    start_burst(4'h5, 8'd0);
    repeat (2) @(negedge clk);
    check("zero_len_done", bus.done, 1);
    drain("zero_len_drain");
    // pause beats same-cycle tick, paused ticks discarded
    push_run(0, 4, 4'h1);
    push_k(K_DONE);
    start_burst(4'h1, 8'd4);
    ticks(1);
    repeat (2) @(negedge clk);
    bus.pause = 1'b1;
    bus.tick_en = 1'b1;
    @(negedge clk);
    bus.tick_en = 1'b0;
    ticks(2);
    check("paused_busy", bus.busy, 1);
    check("paused_hold", bus.lfsr_out, 4'h1);
    bus.pause = 1'b0;
    @(negedge clk);
    ticks(3);
    drain("pause_drain");
    // abort beats tick
    push_run(4, 1, 4'h3);
    start_burst(4'h3, 8'd5);
    ticks(1);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    bus.tick_en = 1'b1;
    @(negedge clk);
    {bus.abort, bus.tick_en} = '0;
    check("abort_idle", bus.busy, 0);
    check("abort_hold", bus.lfsr_out, 4'h3);
    drain("abort_drain");
    // start+abort in IDLE accepted; start while busy ignored
    push_run(0, 2, 4'h1);
    push_k(K_DONE);
    @(negedge clk);
    bus.seed = 4'h1;
    bus.burst_len = 8'd2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    {bus.start, bus.abort} = '0;
    check("start_abort_busy", bus.busy, 1);
    repeat (2) @(negedge clk);
    start_burst(4'hF, 8'd9);
    ticks(2);
    drain("busy_start_drain");
    check("busy_start_idle", bus.busy, 0);
    // reset mid-run
    push_run(0, 1, 4'h1);
    start_burst(4'h1, 8'd5);
    ticks(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_midrun", outs(), 0);
    drain("reset_drain");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
